// File: rtl/pulse_ripple_counter_if.sv
// Output bundle of pulse_ripple_counter: prescaler tick, counter value and carry/overflow flag.
interface pulse_ripple_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             o_pulse;
    logic [WIDTH-1:0] o_q;
    logic             o_carry;

    modport master (output o_pulse, output o_q, output o_carry);
    modport slave  (input  o_pulse, input  o_q, input  o_carry);
endinterface

// File: rtl/pulse_ripple_counter.sv
// Heartbeat counter: a DIV_N prescaler tick advances a WIDTH-bit toggle/carry-chain up-counter.
// Optional build macro PULSE_RIPPLE_COUNTER_SATURATE_EN: hold at all-ones and make o_carry a sticky overflow flag.
module pulse_ripple_counter #(
    parameter int unsigned DIV_N = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    pulse_ripple_counter_if.master o_if
);
    localparam int unsigned PRE_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV_N - 1);

    if (DIV_N < 2 || DIV_N > 65536) begin : g_bad_div_n
        $error("pulse_ripple_counter: DIV_N=%0d outside 2..65536", DIV_N);
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pulse_ripple_counter: WIDTH=%0d outside 1..32", WIDTH);
    end

    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] w_pre_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_toggle;
    logic             w_wrap;

    // Toggle enables rippled from bit 0 upward; the final carry marks a pulse at all-ones.
    always_comb begin
        logic v_carry;
        v_carry  = r_pulse;
        w_toggle = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_toggle[i] = v_carry;
            v_carry     = v_carry & r_q[i];
        end
        w_wrap = v_carry;
    end

    always_comb begin
        w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
        if (r_pre_cnt == PRE_MAX) begin
            w_pre_cnt_nxt = '0;
        end
        w_pulse_nxt = (r_pre_cnt == PRE_MAX);
    end

`ifdef PULSE_RIPPLE_COUNTER_SATURATE_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // A pulse arriving at all-ones holds the count and latches overflow.
    always_comb begin
        w_q_nxt   = r_q ^ w_toggle;
        w_ovf_nxt = r_ovf | w_wrap;
        if (w_wrap) begin
            w_q_nxt = r_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign o_if.o_carry = r_ovf;
`else
    always_comb begin
        w_q_nxt = r_q ^ w_toggle;
    end

    assign o_if.o_carry = w_wrap;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre_cnt <= '0;
            r_pulse   <= 1'b0;
            r_q       <= '0;
        end else begin
            r_pre_cnt <= w_pre_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
            r_q       <= w_q_nxt;
        end
    end

    assign o_if.o_pulse = r_pulse;
    assign o_if.o_q     = r_q;
endmodule

// File: tb/tb_pulse_ripple_counter.sv
// Scoreboard bench for pulse_ripple_counter: two configurations against an edge-count reference model.
module tb_pulse_ripple_counter;
    localparam int unsigned A_DIV = 4;
    localparam int unsigned A_W   = 4;
    localparam int unsigned B_DIV = 2;
    localparam int unsigned B_W   = 1;

    typedef struct packed {
        logic        p;
        logic [31:0] q;
        logic        c;
    } exp_t;

    typedef struct packed {
        longint cyc;
        exp_t   a;
        exp_t   b;
    } item_t;

    logic   clk;
    logic   rst_n;
    int     n_vec;
    int     n_err;
    longint n_edges;
    longint cyc;
    item_t  sb[$];

    pulse_ripple_counter_if #(.WIDTH(A_W)) if_a ();
    pulse_ripple_counter_if #(.WIDTH(B_W)) if_b ();

    pulse_ripple_counter #(.DIV_N(A_DIV), .WIDTH(A_W)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .o_if(if_a)
    );
    pulse_ripple_counter #(.DIV_N(B_DIV), .WIDTH(B_W)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .o_if(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after n edges since reset release: pulses follow edges k*div,
    // and each pulse is counted on the edge after it.
    function automatic exp_t model(input longint n, input int unsigned div, input int unsigned w);
        exp_t   e;
        longint raw;
        longint maxv;
        raw  = (n == 0) ? 0 : (n - 1) / longint'(div);
        maxv = (longint'(1) << w) - 1;
        e.p  = (n > 0) && ((n % longint'(div)) == 0);
`ifdef PULSE_RIPPLE_COUNTER_SATURATE_EN
        e.q = 32'((raw > maxv) ? maxv : raw);
        e.c = (raw > maxv);
`else
        e.q = 32'(raw % (maxv + 1));
        e.c = e.p && (longint'(e.q) == maxv);
`endif
        return e;
    endfunction

    task automatic step(input logic r);
        item_t it;
        @(negedge clk);
        rst_n = r;
        @(posedge clk);
        cyc++;
        n_edges = r ? n_edges + 1 : 0;
        it.cyc  = cyc;
        it.a    = model(n_edges, A_DIV, A_W);
        it.b    = model(n_edges, B_DIV, B_W);
        sb.push_back(it);
    endtask

    task automatic chk(input string name, input longint c, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
        end
    endtask

    // Monitor: the DUTs present a fresh output every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        item_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            chk("a_pulse", it.cyc, 32'(if_a.o_pulse), 32'(it.a.p));
            chk("a_q",     it.cyc, 32'(if_a.o_q),     it.a.q);
            chk("a_carry", it.cyc, 32'(if_a.o_carry), 32'(it.a.c));
            chk("b_pulse", it.cyc, 32'(if_b.o_pulse), 32'(it.b.p));
            chk("b_q",     it.cyc, 32'(if_b.o_q),     it.b.q);
            chk("b_carry", it.cyc, 32'(if_b.o_carry), 32'(it.b.c));
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        n_edges = 0;
        cyc     = 0;
        rst_n   = 1'b0;

        // Reset hold, then long run past wrap / saturation of the 4-bit counter.
        for (int i = 0; i < 6; i++) step(1'b0);
        for (int i = 0; i < 100; i++) step(1'b1);

        // Mid-run reset at o_q=7 (29 edges after release), then observe restart.
        for (int i = 0; i < 2; i++) step(1'b0);
        for (int i = 0; i < 29; i++) step(1'b1);
        step(1'b0);
        for (int i = 0; i < 40; i++) step(1'b1);

        // Random reset sprinkling.
        for (int i = 0; i < 1500; i++) step(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", cyc, 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
